// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package fetch_pkg;

  localparam int FETCH_XLEN  = 64;
  localparam int FETCH_ILEN  = 32;
  localparam int INSTR_BYTES = FETCH_ILEN / 8;

  // One queue slot: fetch address, returned instruction, and whether the
  // instruction has arrived yet.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_ILEN-1:0] instr;
    logic                  filled;
  } fetch_entry_t;

  // Pointer width for a power-of-two queue depth.
  function automatic int clog2_depth(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_ring.sv
// In-order fetch ring: entries are allocated at request time, filled in
// response order and popped from the head. flush empties everything.
module fetch_ring_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = clog2_depth(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alloc_en,
  input  logic [FETCH_XLEN-1:0] alloc_pc,
  input  logic                  fill_en,
  input  logic [FETCH_ILEN-1:0] fill_instr,
  input  logic                  pop_en,
  output logic                  head_valid,
  output logic [FETCH_XLEN-1:0] head_pc,
  output logic [FETCH_ILEN-1:0] head_instr,
  output logic [PW:0]           occ
);

  fetch_entry_t    entry_reg [DEPTH];
  logic [PW-1:0]   head_ptr_reg;
  logic [PW-1:0]   alloc_ptr_reg;
  logic [PW-1:0]   fill_ptr_reg;
  logic [PW:0]     occ_reg;
  logic            do_pop;
  logic [DEPTH-1:0] alloc_hit;
  logic [DEPTH-1:0] fill_hit;
  logic [DEPTH-1:0] pop_hit;
  fetch_entry_t    head_entry;

  assign head_entry = entry_reg[head_ptr_reg];
  assign head_valid = (occ_reg != '0) && head_entry.filled;
  assign head_pc    = head_entry.pc;
  assign head_instr = head_entry.instr;
  assign occ        = occ_reg;
  assign do_pop     = pop_en && head_valid;

  // Per-slot write-enable decode.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_dec
      assign alloc_hit[gi] = alloc_en && (alloc_ptr_reg == PW'(gi));
      assign fill_hit[gi]  = fill_en  && (fill_ptr_reg  == PW'(gi));
      assign pop_hit[gi]   = do_pop   && (head_ptr_reg  == PW'(gi));
    end
  endgenerate

  // Pointer, occupancy and slot updates; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr_reg  <= '0;
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      occ_reg       <= '0;
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      if (alloc_en) alloc_ptr_reg <= alloc_ptr_reg + 1'b1;
      if (fill_en)  fill_ptr_reg  <= fill_ptr_reg + 1'b1;
      if (do_pop)   head_ptr_reg  <= head_ptr_reg + 1'b1;
      case ({alloc_en, do_pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (pop_hit[i]) entry_reg[i] <= '0;
        if (alloc_hit[i]) begin
          entry_reg[i].pc     <= alloc_pc;
          entry_reg[i].instr  <= '0;
          entry_reg[i].filled <= 1'b0;
        end
        if (fill_hit[i]) begin
          entry_reg[i].instr  <= fill_instr;
          entry_reg[i].filled <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled instruction fetch stage: PC generation, valid/ready imem
// requests with arbitrary response latency, EX redirect with stale
// response dropping, and a valid/ready handoff to decode.
// Optional macro FETCH_PERF_EN adds saturating performance counters.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushes,
  output logic [31:0]     perf_stall_cycles
`endif
);

  localparam int          PW      = clog2_depth(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_reg;
  logic [PW:0]     inflight_reg;
  logic [PW:0]     inflight_next;
  logic [PW:0]     drop_cnt_reg;
  logic [PW:0]     occ;
  logic            req_fire;
  logic            rsp_stale;
  logic            pop_fire;

  assign imem_req_valid = !rst && (occ < DEPTH_C) && (inflight_reg < DEPTH_C);
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_stale      = (drop_cnt_reg != '0);
  assign pop_fire       = if_valid && id_ready && !redirect_valid;

  // Outstanding requests after this cycle's request and response events.
  always_comb begin
    inflight_next = inflight_reg + {{PW{1'b0}}, req_fire} - {{PW{1'b0}}, imem_rsp_valid};
  end

  // PC, in-flight and stale-drop bookkeeping; redirect overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
      if (redirect_valid) begin
        pc_reg       <= redirect_pc;
        drop_cnt_reg <= inflight_next;
      end else begin
        if (req_fire) pc_reg <= pc_reg + XLEN'(INSTR_BYTES);
        if (imem_rsp_valid && rsp_stale) drop_cnt_reg <= drop_cnt_reg - 1'b1;
      end
    end
  end

  fetch_ring_buffer #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .alloc_en   (req_fire && !redirect_valid),
    .alloc_pc   (pc_reg),
    .fill_en    (imem_rsp_valid && !rsp_stale && !redirect_valid),
    .fill_instr (imem_rsp_data),
    .pop_en     (id_ready && !redirect_valid),
    .head_valid (if_valid),
    .head_pc    (if_pc),
    .head_instr (if_instr),
    .occ        (occ)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_flushes_reg;
  logic [31:0] perf_stall_reg;

  assign perf_fetched      = perf_fetched_reg;
  assign perf_flushes      = perf_flushes_reg;
  assign perf_stall_cycles = perf_stall_reg;

  // Saturating event counters for pops, flushes and decode back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_reg <= '0;
      perf_flushes_reg <= '0;
      perf_stall_reg   <= '0;
    end else begin
      if (pop_fire && (perf_fetched_reg != '1))
        perf_fetched_reg <= perf_fetched_reg + 1'b1;
      if (redirect_valid && (perf_flushes_reg != '1))
        perf_flushes_reg <= perf_flushes_reg + 1'b1;
      if (if_valid && !id_ready && (perf_stall_reg != '1))
        perf_stall_reg <= perf_stall_reg + 1'b1;
    end
  end
`else
  logic unused_pop;
  assign unused_pop = pop_fire;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: behavioural imem with
// programmable latency, scoreboard of expected (pc, instr) pops.
module tb_fetch_queue_unit;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        id_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
  logic [31:0] perf_stall_cycles;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int lat     = 1;
  int edge_no = 0;
  pend_t pend_q[$];
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF ^ {a[15:0], 16'h0000};
  endfunction

  // Behavioural imem: in-order responses, 'lat' edges after the request.
  // Expectations are pushed when a non-flushed request is issued.
  initial begin : imem_model
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pend_q.delete();
        exp_q.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if (pend_q.size() > 0 && pend_q[0].due <= edge_no) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(pend_q[0].addr);
          void'(pend_q.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
        if (redirect_valid) exp_q.delete();
        if (imem_req_valid && imem_req_ready) begin
          pend_q.push_back('{addr: imem_req_addr, due: edge_no + lat});
          if (!redirect_valid)
            exp_q.push_back('{pc: imem_req_addr, instr: instr_of(imem_req_addr)});
        end
      end
      edge_no++;
    end
  end

  // Scoreboard: every pop must match the oldest outstanding expectation.
  initial begin : pop_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && if_valid && id_ready && !redirect_valid) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL pop_unexpected: got pc=%h instr=%h, expected no pop", if_pc, if_instr);
        end else begin
          e = exp_q.pop_front();
          if (if_pc !== e.pc || if_instr !== e.instr)
            $display("FAIL pop_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                     if_pc, if_instr, e.pc, e.instr);
          else begin
            n_pass++;
            $display("pop pc=%h instr=%h", if_pc, if_instr);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_req_ready = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; lat = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
    #4;
    n_total++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid: got %b, expected 0", if_valid); else n_pass++;
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid); else n_pass++;
    n_total++; if (imem_req_addr !== 64'h0) $display("FAIL rst_req_addr: got %h, expected 0", imem_req_addr); else n_pass++;
    n_total++; if (if_instr !== 32'h0) $display("FAIL rst_if_instr: got %h, expected 0", if_instr); else n_pass++;
    n_total++; if (if_pc !== 64'h0) $display("FAIL rst_if_pc: got %h, expected 0", if_pc); else n_pass++;
`ifdef FETCH_PERF_EN
    n_total++;
    if (perf_fetched !== 32'd0 || perf_flushes !== 32'd0 || perf_stall_cycles !== 32'd0)
      $display("FAIL rst_perf: got %0d/%0d/%0d, expected 0/0/0", perf_fetched, perf_flushes, perf_stall_cycles);
    else n_pass++;
`endif
    @(negedge clk);
    #4;
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL rst2_req_valid: got %b, expected 0", imem_req_valid); else n_pass++;
    @(negedge clk);
    rst = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0;
    #4;
    n_total++; if (imem_req_valid !== 1'b1) $display("FAIL post_rst_req_valid: got %b, expected 1", imem_req_valid); else n_pass++;
    n_total++; if (imem_req_addr !== 64'h0) $display("FAIL post_rst_req_addr: got %h, expected 0", imem_req_addr); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    #4;
    n_total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0)
      $display("FAIL stream_first_req: got v=%b addr=%h, expected v=1 addr=0", imem_req_valid, imem_req_addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL stream_obs0_valid: got %b, expected 0", if_valid); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #4;
      if (k == 1) begin
        n_total++; if (if_valid !== 1'b0) $display("FAIL stream_obs1_valid: got %b, expected 0", if_valid); else n_pass++;
      end else begin
        n_total++;
        if (if_valid !== 1'b1 || if_pc !== 64'((k - 2) * 4))
          $display("FAIL stream_pc: got v=%b pc=%h, expected v=1 pc=%h", if_valid, if_pc, 64'((k - 2) * 4));
        else n_pass++;
      end
    end
  endtask

  task automatic test_full();
    int fires;
    do_reset();
    lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
    fires = 0;
    #4;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #4;
      end
      if (imem_req_valid && imem_req_ready) fires++;
    end
    n_total++; if (fires !== 4) $display("FAIL full_fire_count: got %0d, expected 4", fires); else n_pass++;
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL full_req_valid: got %b, expected 0", imem_req_valid); else n_pass++;
    n_total++; if (if_valid !== 1'b1 || if_pc !== 64'h0)
      $display("FAIL full_head: got v=%b pc=%h, expected v=1 pc=0", if_valid, if_pc); else n_pass++;
    @(negedge clk);
    id_ready = 1'b1;
    #4;
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL full_rel_req_valid: got %b, expected 0", imem_req_valid); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #4;
      if (k == 1) begin
        n_total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h10)
          $display("FAIL full_resume_req: got v=%b addr=%h, expected v=1 addr=10", imem_req_valid, imem_req_addr); else n_pass++;
      end
      n_total++;
      if (if_valid !== 1'b1 || if_pc !== 64'(k * 4))
        $display("FAIL full_drain_pc: got v=%b pc=%h, expected v=1 pc=%h", if_valid, if_pc, 64'(k * 4));
      else n_pass++;
    end
  endtask

  task automatic test_redirect_drop();
    int  waited;
    logic found;
    do_reset();
    lat = 3; imem_req_ready = 1'b1; id_ready = 1'b1;
    #4;
    @(negedge clk);
    #4;
    n_total++; if (imem_req_addr !== 64'h4) $display("FAIL rd_second_req: got %h, expected 4", imem_req_addr); else n_pass++;
    @(negedge clk);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h40;
    #4;
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #4;
    n_total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h40)
      $display("FAIL rd_resume_req: got v=%b addr=%h, expected v=1 addr=40", imem_req_valid, imem_req_addr); else n_pass++;
    n_total++; if (if_valid !== 1'b0) $display("FAIL rd_flushed_valid: got %b, expected 0", if_valid); else n_pass++;
    found = 1'b0; waited = 0;
    while (!found && waited < 20) begin
      @(negedge clk);
      #4;
      waited++;
      if (if_valid) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL rd_timeout: got no if_valid in %0d cycles, expected one", waited); else n_pass++;
    n_total++; if (waited !== 4) $display("FAIL rd_latency: got %0d cycles, expected 4", waited); else n_pass++;
    n_total++; if (if_pc !== 64'h40 || if_instr !== instr_of(64'h40))
      $display("FAIL rd_first_out: got pc=%h instr=%h, expected pc=40 instr=%h", if_pc, if_instr, instr_of(64'h40)); else n_pass++;
  endtask

  task automatic test_redirect_pop();
    int  waited;
    logic found;
    do_reset();
    lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    #4;
    @(negedge clk); #4;
    @(negedge clk); #4;
    n_total++; if (if_valid !== 1'b1 || if_pc !== 64'h0)
      $display("FAIL rp_head0: got v=%b pc=%h, expected v=1 pc=0", if_valid, if_pc); else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    #4;
    n_total++; if (if_valid !== 1'b1 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'hC)
      $display("FAIL rp_collide: got if_v=%b req_v=%b addr=%h, expected 1 1 c", if_valid, imem_req_valid, imem_req_addr); else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    n_total++; if (if_valid !== 1'b0 || imem_req_addr !== 64'h100)
      $display("FAIL rp_after: got v=%b addr=%h, expected v=0 addr=100", if_valid, imem_req_addr); else n_pass++;
`ifdef FETCH_PERF_EN
    n_total++; if (perf_fetched !== 32'd1 || perf_flushes !== 32'd1)
      $display("FAIL rp_perf: got fetched=%0d flushes=%0d, expected 1 1", perf_fetched, perf_flushes); else n_pass++;
`endif
    found = 1'b0; waited = 0;
    while (!found && waited < 20) begin
      @(negedge clk);
      #4;
      waited++;
      if (if_valid) found = 1'b1;
    end
    n_total++; if (!found || waited !== 2)
      $display("FAIL rp_latency: got found=%b after %0d cycles, expected found=1 after 2", found, waited); else n_pass++;
    n_total++; if (if_pc !== 64'h100 || if_instr !== instr_of(64'h100))
      $display("FAIL rp_first_out: got pc=%h instr=%h, expected pc=100 instr=%h", if_pc, if_instr, instr_of(64'h100)); else n_pass++;
    @(negedge clk);
    #4;
    n_total++; if (if_pc !== 64'h104) $display("FAIL rp_second_out: got %h, expected 104", if_pc); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1; imem_req_ready = 1'b0; id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    #4;
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    #4;
    n_total++; if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL wrap_top_addr: got %h, expected fffffffffffffffc", imem_req_addr); else n_pass++;
    @(negedge clk);
    #4;
    n_total++; if (imem_req_addr !== 64'h0) $display("FAIL wrap_next_addr: got %h, expected 0", imem_req_addr); else n_pass++;
    @(negedge clk);
    #4;
    n_total++; if (if_valid !== 1'b1 || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL wrap_out0: got v=%b pc=%h, expected v=1 pc=fffffffffffffffc", if_valid, if_pc); else n_pass++;
    @(negedge clk);
    #4;
    n_total++; if (if_valid !== 1'b1 || if_pc !== 64'h0)
      $display("FAIL wrap_out1: got v=%b pc=%h, expected v=1 pc=0", if_valid, if_pc); else n_pass++;
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    lat = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
    #4;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #4;
    end
    for (int k = 7; k <= 9; k++) begin
      @(negedge clk);
      id_ready = 1'b1;
      #4;
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    #4;
    @(negedge clk);
    redirect_valid = 1'b0;
    #4;
    n_total++; if (perf_stall_cycles !== 32'd5) $display("FAIL perf_stall: got %0d, expected 5", perf_stall_cycles); else n_pass++;
    n_total++; if (perf_flushes !== 32'd1) $display("FAIL perf_flushes: got %0d, expected 1", perf_flushes); else n_pass++;
    n_total++; if (perf_fetched !== 32'd3) $display("FAIL perf_fetched: got %0d, expected 3", perf_fetched); else n_pass++;
  endtask
`endif

  initial begin : main
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_pop();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    do_reset();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
